// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One combinational iteration: a shift-add multiply step or a restoring
// divide step on unsigned magnitudes.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             low_bit,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_next,
  output logic             q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum      = {1'b0, acc} + (low_bit ? {1'b0, operand} : '0);
    shifted  = {acc, low_bit};
    trial    = shifted - {1'b0, operand};
    acc_next = sum[WIDTH:1];
    q_bit    = sum[0];
    if (is_div) begin
      // A set top bit of the trial difference means the subtract went negative.
      if (trial[WIDTH]) begin
        acc_next = shifted[WIDTH-1:0];
        q_bit    = 1'b0;
      end else begin
        acc_next = trial[WIDTH-1:0];
        q_bit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit; results feed the HI/LO registers and
// resultValid is their one-cycle write enable.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hiResult,
  output logic [WIDTH-1:0] loResult,
  output logic             resultValid
);

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg, sign_res_reg, sign_rem_reg, dz_reg;
  logic [WIDTH-1:0] acc_reg, lo_reg, opnd_reg;
  logic [WIDTH-1:0] hi_result_reg, lo_result_reg;

  logic             op_div, op_signed, a_neg, b_neg, div_zero, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] core_acc_next;
  logic             core_q;
  logic [WIDTH-1:0] hi_fix, lo_fix;

  always_comb begin
    op_div    = op[1];
    op_signed = ~op[0];
    a_neg     = op_signed & srcA[WIDTH-1];
    b_neg     = op_signed & srcB[WIDTH-1];
    mag_a     = a_neg ? -srcA : srcA;
    mag_b     = b_neg ? -srcB : srcB;
    div_zero  = op_div && (srcB == '0);
    accept    = start && !flush;
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .acc      (acc_reg),
    .low_bit  (is_div_reg ? lo_reg[WIDTH-1] : lo_reg[0]),
    .operand  (opnd_reg),
    .is_div   (is_div_reg),
    .acc_next (core_acc_next),
    .q_bit    (core_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Divide by zero skips the iterations and spends a single FIX cycle,
  // so its valid pulse appears one edge after the operands are latched.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = div_zero ? FIX : RUN;
      RUN: begin
        if (flush)                                state_next = IDLE;
        else if (cnt_reg == CNT_W'(WIDTH - 1))    state_next = FIX;
      end
      FIX:     state_next = flush ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hi_fix = acc_reg;
    lo_fix = lo_reg;
    if (dz_reg) begin
      // Undo the magnitude conversion so HI returns the dividend unchanged.
      lo_fix = '1;
      hi_fix = sign_rem_reg ? -lo_reg : lo_reg;
    end else if (is_div_reg) begin
      lo_fix = sign_res_reg ? -lo_reg  : lo_reg;
      hi_fix = sign_rem_reg ? -acc_reg : acc_reg;
    end else if (sign_res_reg) begin
      {hi_fix, lo_fix} = -{acc_reg, lo_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      is_div_reg    <= 1'b0;
      sign_res_reg  <= 1'b0;
      sign_rem_reg  <= 1'b0;
      dz_reg        <= 1'b0;
      acc_reg       <= '0;
      lo_reg        <= '0;
      opnd_reg      <= '0;
      hi_result_reg <= '0;
      lo_result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            is_div_reg   <= op_div;
            sign_res_reg <= a_neg ^ b_neg;
            sign_rem_reg <= op_div & a_neg;
            dz_reg       <= div_zero;
            opnd_reg     <= op_div ? mag_b : mag_a;
            lo_reg       <= op_div ? mag_a : mag_b;
            acc_reg      <= '0;
            cnt_reg      <= '0;
          end
        end
        RUN: begin
          acc_reg <= core_acc_next;
          lo_reg  <= is_div_reg ? {lo_reg[WIDTH-2:0], core_q}
                                : {core_q, lo_reg[WIDTH-1:1]};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        FIX: begin
          if (!flush) begin
            hi_result_reg <= hi_fix;
            lo_result_reg <= lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg == RUN) || (state_reg == FIX);
  assign resultValid = (state_reg == DONE);
  assign hiResult    = hi_result_reg;
  assign loResult    = lo_result_reg;

endmodule
